// File: rtl/wb_dev_bridge.sv
// Registered Wishbone-slave splitter for the device I/O space: decodes the slot index,
// forwards one registered request to the selected device and returns ack/data or an error.
//   state | meaning
//   IDLE  | waiting for cyc&stb; decodes slot index
//   REQ   | device selected, waiting for its ack, an abort or the timeout
//   DONE  | one-cycle ack or err pulse, then clear everything
module wb_dev_bridge #(
    parameter int DEV_NUM          = 10,
    parameter int TOTAL_ADDR_BITS  = 16,
    parameter int SINGLE_ADDR_BITS = 8,
    parameter int TIMEOUT          = 255,
    parameter int TIMEOUT_BITS     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic [TOTAL_ADDR_BITS-3:0]    wbs_addr_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic                          wbs_we_i,
    input  logic [31:0]                   wbs_data_i,
    output logic [31:0]                   wbs_data_o,
    output logic                          wbs_ack_o,
    output logic                          wbs_err_o,
    output logic [DEV_NUM-1:0]            dev_cs_o,
    output logic [SINGLE_ADDR_BITS-3:0]   dev_addr_o,
    output logic [3:0]                    dev_sel_o,
    output logic                          dev_we_o,
    output logic [31:0]                   dev_data_o,
    input  logic [32*DEV_NUM-1:0]         dev_data_i,
    input  logic [DEV_NUM-1:0]            dev_ack_i
);
    localparam int IDXW = TOTAL_ADDR_BITS - SINGLE_ADDR_BITS;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST =
        TIMEOUT_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]                  state_q, state_d;
    logic [TIMEOUT_BITS-1:0]     cnt_q, cnt_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic [DEV_NUM-1:0]          cs_q, cs_d;
    logic [SINGLE_ADDR_BITS-3:0] addr_q, addr_d;
    logic [3:0]                  sel_q, sel_d;
    logic                        we_q, we_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;

    logic [IDXW-1:0]    idx_w;
    logic [DEV_NUM-1:0] onehot;
    logic               sel_ack;
    logic [31:0]        sel_data;

    assign idx_w = wbs_addr_i[TOTAL_ADDR_BITS-3:SINGLE_ADDR_BITS-2];

    // Loop-based decode/mux keeps index widths independent of DEV_NUM.
    always_comb begin
        onehot   = '0;
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < DEV_NUM; k++) begin
            if (idx_w == IDXW'(k)) onehot[k] = 1'b1;
            if (idx_q == IDXW'(k)) begin
                sel_ack  = dev_ack_i[k];
                sel_data = dev_data_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cs_d    = cs_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (32'(idx_w) < DEV_NUM) begin
                        idx_d   = idx_w;
                        addr_d  = wbs_addr_i[SINGLE_ADDR_BITS-3:0];
                        sel_d   = wbs_sel_i;
                        we_d    = wbs_we_i;
                        wdata_d = wbs_data_i;
                        cs_d    = onehot;
                        cnt_d   = '0;
                        state_d = REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (!wbs_cyc_i) begin
                    cs_d    = '0;
                    addr_d  = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    rdata_d = we_q ? 32'd0 : sel_data;
                    ack_d   = 1'b1;
                    cs_d    = '0;
                    state_d = DONE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cs_d    = '0;
                    state_d = DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                cs_d    = '0;
                addr_d  = '0;
                sel_d   = '0;
                we_d    = 1'b0;
                wdata_d = '0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cs_q    <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign wbs_data_o = rdata_q;
    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign dev_cs_o   = cs_q;
    assign dev_addr_o = addr_q;
    assign dev_sel_o  = sel_q;
    assign dev_we_o   = we_q;
    assign dev_data_o = wdata_q;
endmodule
